// File: rtl/cache_mem_responder_if.sv
// Read/write request bus, read-return bus and SRAM port of cache_mem_responder.
// master = requester plus SRAM model; slave = the responder.
interface cache_mem_responder_if #(
  parameter int ADDR_W = 14
);
  logic              rd_req;
  logic [2:0]        rd_type;
  logic [31:0]       rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [31:0]       ret_data;
  logic              wr_req;
  logic [2:0]        wr_type;
  logic [31:0]       wr_addr;
  logic [3:0]        wr_wstrb;
  logic [127:0]      wr_data;
  logic              wr_rdy;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data, ram_rdata,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data, ram_rdata,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Serves single-word and 4-word line reads/writes from a synchronous single-port SRAM.
// Define RESP_RD_LATENCY_EN to insert RD_LATENCY wait cycles before the first read beat.
module cache_mem_responder #(
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_mem_responder_if.slave bus
);

`ifdef RESP_RD_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif
  localparam logic [15:0] WAIT_LAST = 16'(RD_LATENCY - 1);
  localparam logic [2:0]  TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT} state_t;

  // Line transfers always start at word 0 of the line, whatever addr[3:2] says.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] w_in,
                                                  input logic              line);
    logic [ADDR_W-1:0] w;
    w = w_in;
    if (line) w[1:0] = 2'b00;
    return w;
  endfunction

  function automatic logic [2:0] beat_count(input logic line);
    return line ? 3'd4 : 3'd1;
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [15:0]       wait_cnt, wait_cnt_nxt;
  logic              ret_vld_p1, ret_last_p1;
  logic              ret_vld_nxt, ret_last_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              is_line_q;
  logic [127:0]      wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        beats;
  logic              idle, rd_accept, wr_accept;
  logic              ram_en, ram_en_rd;
  logic [3:0]        ram_we;
  logic              unused_addr_bits;

  assign idle      = (state == IDLE);
  assign rd_accept = idle && bus.rd_req;
  assign wr_accept = idle && !bus.rd_req && bus.wr_req;
  assign beats     = beat_count(is_line_q);

  assign unused_addr_bits = ^{bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                              bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

  // Request capture: inputs are sampled once at acceptance and then ignored.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      addr_q    <= word_addr(bus.rd_addr[ADDR_W+1:2], bus.rd_type == TYPE_LINE);
      is_line_q <= (bus.rd_type == TYPE_LINE);
    end else if (wr_accept) begin
      addr_q    <= word_addr(bus.wr_addr[ADDR_W+1:2], bus.wr_type == TYPE_LINE);
      is_line_q <= (bus.wr_type == TYPE_LINE);
      wdata_q   <= bus.wr_data;
      wstrb_q   <= bus.wr_wstrb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      wait_cnt    <= 16'd0;
      ret_vld_p1  <= 1'b0;
      ret_last_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      ret_vld_p1  <= ret_vld_nxt;
      ret_last_p1 <= ret_last_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wait_cnt_nxt = wait_cnt;
    ret_vld_nxt  = 1'b0;
    ret_last_nxt = 1'b0;
    ram_en       = 1'b0;
    ram_en_rd    = 1'b0;
    ram_we       = 4'h0;
    case (state)
      IDLE: begin
        cnt_nxt      = 3'd0;
        wait_cnt_nxt = 16'd0;
        if (bus.rd_req)      state_nxt = (LAT_EN && RD_LATENCY > 0) ? RD_WAIT : RD_BEAT;
        else if (bus.wr_req) state_nxt = WR_BEAT;
      end
      RD_WAIT: begin
        wait_cnt_nxt = wait_cnt + 16'd1;
        if (wait_cnt == WAIT_LAST) state_nxt = RD_BEAT;
      end
      // Reads issue back to back; the beat returns one cycle later and the
      // FSM leaves only once the final beat is on the return bus.
      RD_BEAT: begin
        if (cnt < beats) begin
          ram_en_rd    = 1'b1;
          cnt_nxt      = cnt + 3'd1;
          ret_vld_nxt  = 1'b1;
          ret_last_nxt = (cnt == beats - 3'd1);
        end
        ram_en = ram_en_rd;
        if (ret_last_p1) state_nxt = IDLE;
      end
      WR_BEAT: begin
        ram_en  = 1'b1;
        ram_we  = is_line_q ? 4'hF : wstrb_q;
        cnt_nxt = cnt + 3'd1;
        if (cnt == beats - 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = addr_q | ADDR_W'(cnt[1:0]);
  assign bus.ram_wdata = wdata_q[32*cnt[1:0] +: 32];

  assign bus.rd_rdy    = idle && !reset;
  assign bus.wr_rdy    = idle && !reset && !bus.rd_req;
  assign bus.ret_valid = ret_vld_p1;
  assign bus.ret_last  = ret_last_p1;
  assign bus.ret_data  = ret_vld_p1 ? bus.ram_rdata : 32'h0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: expected beats/writes are queued when a
// request is driven and compared (data and cycle) as the DUT produces them.
module tb_cache_mem_responder;
  localparam int ADDR_W     = 14;
  localparam int RD_LATENCY = 2;
`ifdef RESP_RD_LATENCY_EN
  localparam int E = RD_LATENCY;
`else
  localparam int E = 0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  beat_t rq[$];
  wr_t   wq[$];
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  cache_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  cache_mem_responder #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LATENCY)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port SRAM model (read-before-write, byte enables).
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rd(input logic [2:0] ty, input logic [31:0] a);
    bus.rd_req  = 1'b1;
    bus.rd_type = ty;
    bus.rd_addr = a;
  endtask

  task automatic drive_wr(input logic [2:0] ty, input logic [31:0] a,
                          input logic [3:0] s, input logic [127:0] d);
    bus.wr_req   = 1'b1;
    bus.wr_type  = ty;
    bus.wr_addr  = a;
    bus.wr_wstrb = s;
    bus.wr_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.rd_rdy, bus.wr_rdy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_rdy got rd=%b wr=%b want 0 0", bus.rd_rdy, bus.wr_rdy);
    end
    checks++;
    if ({bus.ret_valid, bus.ret_last, bus.ram_en, bus.ram_we, bus.ret_data} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outs got vld=%b last=%b en=%b we=%h data=%h want all 0",
               bus.ret_valid, bus.ret_last, bus.ram_en, bus.ram_we, bus.ret_data);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rd_rdy, bus.wr_rdy} !== 2'b11) begin
      failures++;
      $display("FAIL release_rdy got rd=%b wr=%b want 1 1", bus.rd_rdy, bus.wr_rdy);
    end
  endtask

  task automatic test_line_write();
    int t;
    wr_t w;
    logic [127:0] d;
    d = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    tick();
    drive_wr(3'b100, 32'h0000_0120, 4'h0, d);
    t = cyc;
    for (int k = 0; k < 4; k++)
      wq.push_back('{addr: ADDR_W'(32'h48 + k), we: 4'hF, data: d[32*k +: 32], cyc: t + 1 + k});
    tick();
    bus.wr_req = 1'b0; bus.wr_data = '0; bus.wr_addr = '0; bus.wr_wstrb = 4'h0;
    for (int c = t + 1; c <= t + 5; c++) begin
      @(negedge clk);
      if (bus.ram_en) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL lw_extra unexpected ram access at cyc %0d", cyc);
        end else begin
          w = wq.pop_front();
          if (bus.ram_addr !== w.addr || bus.ram_we !== w.we || bus.ram_wdata !== w.data || cyc != w.cyc) begin
            failures++;
            $display("FAIL lw_beat got addr=%h we=%h data=%h cyc=%0d want addr=%h we=%h data=%h cyc=%0d",
                     bus.ram_addr, bus.ram_we, bus.ram_wdata, cyc, w.addr, w.we, w.data, w.cyc);
          end
        end
      end
      if (c == t + 4 || c == t + 5) begin
        checks++;
        if (bus.wr_rdy !== (c == t + 5)) begin
          failures++;
          $display("FAIL lw_wr_rdy cyc=T+%0d got %b want %b", c - t, bus.wr_rdy, (c == t + 5));
        end
      end
      tick();
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL lw_missing got %0d writes left want 0", wq.size());
      wq.delete();
    end
  endtask

  task automatic test_line_read();
    int t;
    beat_t b;
    tick();
    drive_rd(3'b100, 32'h0000_012C);
    t = cyc;
    rq.push_back('{data: 32'h1111_1111, last: 1'b0, cyc: t + 2 + E});
    rq.push_back('{data: 32'h2222_2222, last: 1'b0, cyc: t + 3 + E});
    rq.push_back('{data: 32'h3333_3333, last: 1'b0, cyc: t + 4 + E});
    rq.push_back('{data: 32'h4444_4444, last: 1'b1, cyc: t + 5 + E});
    tick();
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_type = 3'b000;
    for (int c = t + 1; c <= t + 6 + E; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ret_valid) begin
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL lr_extra unexpected beat %h at cyc %0d", bus.ret_data, cyc);
        end else begin
          b = rq.pop_front();
          if (bus.ret_data !== b.data || bus.ret_last !== b.last || cyc != b.cyc) begin
            failures++;
            $display("FAIL lr_beat got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                     bus.ret_data, bus.ret_last, cyc, b.data, b.last, b.cyc);
          end
        end
      end else if (bus.ret_data !== 32'h0 || bus.ret_last !== 1'b0) begin
        failures++;
        $display("FAIL lr_idle_data got data=%h last=%b want 0 0", bus.ret_data, bus.ret_last);
      end
      if (c == t + 5 + E || c == t + 6 + E) begin
        checks++;
        if (bus.rd_rdy !== (c == t + 6 + E)) begin
          failures++;
          $display("FAIL lr_rd_rdy cyc=T+%0d got %b want %b", c - t, bus.rd_rdy, (c == t + 6 + E));
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL lr_missing got %0d beats left want 0", rq.size());
      rq.delete();
    end
  endtask

  task automatic test_partial_write();
    int t;
    wr_t w;
    beat_t b;
    tick();
    drive_wr(3'b010, 32'h0000_0124, 4'b0011, {96'h0, 32'hAABB_CCDD});
    t = cyc;
    wq.push_back('{addr: ADDR_W'(32'h49), we: 4'b0011, data: 32'hAABB_CCDD, cyc: t + 1});
    tick();
    bus.wr_req = 1'b0;
    for (int c = t + 1; c <= t + 2; c++) begin
      @(negedge clk);
      if (bus.ram_en) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL pw_extra unexpected ram access at cyc %0d", cyc);
        end else begin
          w = wq.pop_front();
          if (bus.ram_addr !== w.addr || bus.ram_we !== w.we || bus.ram_wdata !== w.data || cyc != w.cyc) begin
            failures++;
            $display("FAIL pw_write got addr=%h we=%h data=%h cyc=%0d want addr=%h we=%h data=%h cyc=%0d",
                     bus.ram_addr, bus.ram_we, bus.ram_wdata, cyc, w.addr, w.we, w.data, w.cyc);
          end
        end
      end
      if (c == t + 2) begin
        checks++;
        if (bus.wr_rdy !== 1'b1) begin
          failures++;
          $display("FAIL pw_wr_rdy got %b want 1", bus.wr_rdy);
        end
      end
      tick();
    end
    checks++;
    if (wq.size() != 0) begin
      failures++;
      $display("FAIL pw_missing got %0d writes left want 0", wq.size());
      wq.delete();
    end
    drive_rd(3'b010, 32'h0000_0124);
    t = cyc;
    rq.push_back('{data: 32'h2222_CCDD, last: 1'b1, cyc: t + 2 + E});
    tick();
    bus.rd_req = 1'b0;
    for (int c = t + 1; c <= t + 3 + E; c++) begin
      @(negedge clk);
      if (bus.ret_valid) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL pr_extra unexpected beat %h", bus.ret_data);
        end else begin
          b = rq.pop_front();
          if (bus.ret_data !== b.data || bus.ret_last !== b.last || cyc != b.cyc) begin
            failures++;
            $display("FAIL pr_beat got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                     bus.ret_data, bus.ret_last, cyc, b.data, b.last, b.cyc);
          end
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL pr_missing got %0d beats left want 0", rq.size());
      rq.delete();
    end
  endtask

  task automatic test_single_types();
    logic [2:0]  ty [5];
    logic [31:0] ad [5];
    logic [31:0] ex [5];
    int t;
    beat_t b;
    ty = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111};
    ad = '{32'h121, 32'h126, 32'h12B, 32'h12C, 32'h120};
    ex = '{32'h1111_1111, 32'h2222_CCDD, 32'h3333_3333, 32'h4444_4444, 32'h1111_1111};
    for (int i = 0; i < 5; i++) begin
      drive_rd(ty[i], ad[i]);
      t = cyc;
      rq.push_back('{data: ex[i], last: 1'b1, cyc: t + 2 + E});
      tick();
      bus.rd_req = 1'b0;
      for (int c = t + 1; c <= t + 3 + E; c++) begin
        @(negedge clk);
        if (bus.ret_valid) begin
          checks++;
          if (rq.size() == 0) begin
            failures++;
            $display("FAIL st_extra type=%b unexpected beat %h", ty[i], bus.ret_data);
          end else begin
            b = rq.pop_front();
            if (bus.ret_data !== b.data || bus.ret_last !== b.last || cyc != b.cyc) begin
              failures++;
              $display("FAIL st_beat type=%b got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                       ty[i], bus.ret_data, bus.ret_last, cyc, b.data, b.last, b.cyc);
            end
          end
        end
        if (c == t + 2 + E || c == t + 3 + E) begin
          checks++;
          if (bus.rd_rdy !== (c == t + 3 + E)) begin
            failures++;
            $display("FAIL st_rd_rdy type=%b cyc=T+%0d got %b want %b", ty[i], c - t, bus.rd_rdy, (c == t + 3 + E));
          end
        end
        tick();
      end
      checks++;
      if (rq.size() != 0) begin
        failures++;
        $display("FAIL st_missing type=%b got %0d beats left want 0", ty[i], rq.size());
        rq.delete();
      end
    end
  endtask

  task automatic test_arbitration();
    int t;
    bit seen_wr;
    beat_t b;
    seen_wr = 1'b0;
    tick();
    drive_rd(3'b010, 32'h0000_0128);
    drive_wr(3'b010, 32'h0000_012C, 4'hF, {96'h0, 32'h5555_6666});
    t = cyc;
    rq.push_back('{data: 32'h3333_3333, last: 1'b1, cyc: t + 2 + E});
    @(negedge clk);
    checks++;
    if ({bus.rd_rdy, bus.wr_rdy} !== 2'b10) begin
      failures++;
      $display("FAIL arb_rdy got rd=%b wr=%b want 1 0", bus.rd_rdy, bus.wr_rdy);
    end
    tick();
    bus.rd_req = 1'b0;
    for (int c = t + 1; c <= t + 6 + E; c++) begin
      @(negedge clk);
      if (bus.ret_valid) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL arb_extra unexpected beat %h", bus.ret_data);
        end else begin
          b = rq.pop_front();
          if (bus.ret_data !== b.data || bus.ret_last !== b.last || cyc != b.cyc) begin
            failures++;
            $display("FAIL arb_beat got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                     bus.ret_data, bus.ret_last, cyc, b.data, b.last, b.cyc);
          end
        end
      end
      if (bus.ram_en && bus.ram_we != 4'h0) begin
        checks++;
        seen_wr = 1'b1;
        if (bus.ram_addr !== ADDR_W'(32'h4B) || bus.ram_we !== 4'hF ||
            bus.ram_wdata !== 32'h5555_6666 || cyc != t + 4 + E) begin
          failures++;
          $display("FAIL arb_write got addr=%h we=%h data=%h cyc=T+%0d want addr=04b we=f data=55556666 cyc=T+%0d",
                   bus.ram_addr, bus.ram_we, bus.ram_wdata, cyc - t, 4 + E);
        end
      end
      if (c == t + 2 + E || c == t + 3 + E) begin
        checks++;
        if (bus.wr_rdy !== (c == t + 3 + E)) begin
          failures++;
          $display("FAIL arb_wr_rdy cyc=T+%0d got %b want %b", c - t, bus.wr_rdy, (c == t + 3 + E));
        end
      end
      tick();
      if (c == t + 3 + E) bus.wr_req = 1'b0;
    end
    bus.wr_req = 1'b0;
    checks++;
    if (!seen_wr || rq.size() != 0) begin
      failures++;
      $display("FAIL arb_missing got write_seen=%b beats_left=%0d want 1 0", seen_wr, rq.size());
      rq.delete();
    end
  endtask

  task automatic test_zero_strb();
    int t;
    bit seen;
    seen = 1'b0;
    tick();
    drive_wr(3'b010, 32'h0000_0128, 4'h0, {96'h0, 32'hFFFF_FFFF});
    t = cyc;
    tick();
    bus.wr_req = 1'b0;
    for (int c = t + 1; c <= t + 2; c++) begin
      @(negedge clk);
      if (c == t + 1) begin
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 4'h0 || bus.ram_addr !== ADDR_W'(32'h4A)) begin
          failures++;
          $display("FAIL zs_access got en=%b we=%h addr=%h want en=1 we=0 addr=04a",
                   bus.ram_en, bus.ram_we, bus.ram_addr);
        end
      end else begin
        checks++;
        if (bus.wr_rdy !== 1'b1 || bus.ram_en !== 1'b0) begin
          failures++;
          $display("FAIL zs_done got wr_rdy=%b en=%b want 1 0", bus.wr_rdy, bus.ram_en);
        end
      end
      tick();
    end
    drive_rd(3'b010, 32'h0000_0128);
    t = cyc;
    tick();
    bus.rd_req = 1'b0;
    for (int c = t + 1; c <= t + 3 + E; c++) begin
      @(negedge clk);
      if (bus.ret_valid) begin
        checks++;
        seen = 1'b1;
        if (bus.ret_data !== 32'h3333_3333) begin
          failures++;
          $display("FAIL zs_readback got %h want 33333333", bus.ret_data);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL zs_no_beat got no read beat want one");
    end
  endtask

  task automatic test_reset_abort();
    int t;
    beat_t b;
    tick();
    drive_rd(3'b100, 32'h0000_0120);
    t = cyc;
    rq.push_back('{data: 32'h1111_1111, last: 1'b0, cyc: t + 2 + E});
    tick();
    bus.rd_req = 1'b0;
    for (int c = t + 1; c <= t + 9 + E; c++) begin
      if (c == t + 3 + E) reset = 1'b1;
      if (c == t + 4 + E) reset = 1'b0;
      @(negedge clk);
      if (bus.ret_valid) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL ra_extra beat %h at cyc T+%0d after reset", bus.ret_data, cyc - t);
        end else begin
          b = rq.pop_front();
          if (bus.ret_data !== b.data || bus.ret_last !== b.last || cyc != b.cyc) begin
            failures++;
            $display("FAIL ra_beat got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                     bus.ret_data, bus.ret_last, cyc, b.data, b.last, b.cyc);
          end
        end
      end
      if (c >= t + 3 + E) begin
        checks++;
        if (bus.ram_en !== 1'b0 || bus.ret_data !== 32'h0) begin
          failures++;
          $display("FAIL ra_quiet cyc=T+%0d got en=%b data=%h want 0 0", c - t, bus.ram_en, bus.ret_data);
        end
      end
      if (c == t + 3 + E || c == t + 4 + E) begin
        checks++;
        if (bus.rd_rdy !== (c == t + 4 + E)) begin
          failures++;
          $display("FAIL ra_rd_rdy cyc=T+%0d got %b want %b", c - t, bus.rd_rdy, (c == t + 4 + E));
        end
      end
      tick();
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL ra_missing got %0d beats left want 0", rq.size());
      rq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    bus.ram_rdata = 32'h0;
    bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = '0;
    bus.wr_wstrb = 4'h0; bus.wr_data = '0;
    reset = 1'b1;
    test_reset();
    test_line_write();
    test_line_read();
    test_partial_write();
    test_single_types();
    test_arbitration();
    test_zero_strb();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 Parameter ADDR_W, 14: SRAM word-address width; memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter RD_LATENCY, 2: extra wait cycles before the first read beat; used only when RESP_RD_LATENCY_EN is defined.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rd_req  in  1  read request; accepted in a cycle where rd_req && rd_rdy.
REQ-006 rd_type  in  3  000 byte, 001 halfword, 010 word, 100 cache line (4 words).
REQ-007 rd_addr  in  32  read byte address.
REQ-008 rd_rdy  out  1  responder can accept a read.
REQ-009 ret_valid  out  1  ret_data holds a valid beat.
REQ-010 ret_last  out  1  final beat of the current read.
REQ-011 ret_data  out  32  returned word.
REQ-012 wr_req  in  1  write request; accepted in a cycle where wr_req && wr_rdy.
REQ-013 wr_type  in  3  same encoding as rd_type.
REQ-014 wr_addr  in  32  write byte address.
REQ-015 wr_wstrb  in  4  byte enables for non-line writes.
REQ-016 wr_data  in  128  line data; word k in bits [32k+31:32k]; non-line writes use bits [31:0].
REQ-017 wr_rdy  out  1  responder can accept a write.
REQ-018 ram_en, ram_we[3:0], ram_addr[ADDR_W-1:0], ram_wdata[31:0]  out  synchronous single-port SRAM port.
REQ-019 ram_rdata  in  32  SRAM read data, valid the cycle after ram_en with ram_we==0.

Function
REQ-020 FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT.
REQ-021 rd_rdy = (state==IDLE); wr_rdy = (state==IDLE) && !rd_req. A read wins when both requests arrive in the same cycle.
REQ-022 On acceptance, latch the address, the type, and (for writes) wr_data and wr_wstrb; later input changes are ignored.
REQ-023 Beat count: 4 for type 100; 1 for any other encoding, including the illegal encodings 011, 101, 110, 111.
REQ-024 SRAM word address = addr[ADDR_W+1:2]. For line transfers, addr[3:2] is forced to 0 and beats proceed in the order 0, 1, 2, 3 with no wrap or reordering.
REQ-025 Read accepted at cycle T: SRAM reads issue in consecutive cycles from T+1. Beat k appears with ret_valid=1 at T+2+k; ret_last=1 on the final beat only.
REQ-026 Reads always return the full 32-bit word; byte and halfword lane selection is the requester's job.
REQ-027 ret_data = ram_rdata when ret_valid=1, else 0.
REQ-028 Line read: state returns to IDLE so that rd_rdy=1 at T+6; word read: rd_rdy=1 at T+3.
REQ-029 Write accepted at T: line writes issue ram_we=4'hF with words 0..3 at T+1..T+4; other types issue one write with ram_we=wr_wstrb at T+1.
REQ-030 Write completion: wr_rdy=1 again at T+5 for a line write, T+2 for a single write.
REQ-031 A write with wr_wstrb==0 still occupies its cycle with ram_en=1 and ram_we=0; the returned data is discarded.
REQ-032 No requests are accepted outside IDLE, and no pipelining across requests is allowed.
REQ-033 ram_en=0 in every cycle with no SRAM access.

Reset
REQ-034 While reset=1: state=IDLE; ret_valid, ret_last, ret_data, ram_en, ram_we all 0; rd_rdy=wr_rdy=0.
REQ-035 Reset asserted mid-transfer aborts the transfer immediately. Remaining beats are never returned and never written.
REQ-036 First cycle after reset release: rd_rdy=1, and wr_rdy=!rd_req.

Configuration
REQ-037 Macro RESP_RD_LATENCY_EN defined: an accepted read enters RD_WAIT for RD_LATENCY cycles before the first SRAM read, so beat k appears at T+2+RD_LATENCY+k.
REQ-038 RESP_RD_LATENCY_EN undefined: RD_WAIT is unreachable and the timing of REQ-025 applies. Writes are unaffected in both cases.

Verification
REQ-039 Line write to 0x0000_0120, wr_data=128'h4444_4444_3333_3333_2222_2222_1111_1111 -> SRAM words 0x48..0x4B written with 1111_1111..4444_4444 at T+1..T+4; wr_rdy=1 at T+5.
REQ-040 Line read of 0x0000_012C (macro off) -> beats 1111_1111, 2222_2222, 3333_3333, 4444_4444 at T+2..T+5; ret_last only at T+5; rd_rdy=1 at T+6.
REQ-041 Word write to 0x0000_0124, wr_wstrb=4'b0011, data 0xAABB_CCDD, then a word read of the same address -> returns 0x2222_CCDD with ret_valid=ret_last=1 in the same cycle.
REQ-042 rd_req and wr_req asserted together in IDLE -> read accepted, wr_rdy=0; write accepted only after the read completes, with its data unchanged.
REQ-043 Reset pulse at T+3 of a line read -> ret_valid=0 from reset onward, no further beats, rd_rdy=1 after release.
REQ-044 RESP_RD_LATENCY_EN defined, RD_LATENCY=2, word read at T -> ret_valid=ret_last=1 at T+4 only.
